// File: rtl/stage_ex2_div.sv
// Iterative RV64M divider (DIV/DIVU/REM/REMU and W forms), EX stage 2.
// Optional DIV_EARLY_OUT_EN: one-edge return for trivial quotients.
module stage_ex2_div #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_is_32,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_value
);

  if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2) begin : g_bad_bpc
    $error("stage_ex2_div: BITS_PER_CYCLE must be 1 or 2");
  end

  localparam logic [6:0] CNT64 = 7'(64 / BITS_PER_CYCLE);
  localparam logic [6:0] CNT32 = 7'(32 / BITS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q;
  logic [6:0]  cnt_q;
  logic [64:0] rem_q, rem_d;
  logic [63:0] quo_q, quo_d;
  logic [63:0] div_q;
  logic        is_rem_q, w_q, negq_q, negr_q;
  logic        resp_valid_q;
  logic [63:0] resp_value_q;

  logic        signed_op, sa, sb, b_zero, negq;
  logic [63:0] a_ext, b_ext, a_mag, b_mag;
  logic [63:0] q_fix, r_fix, res_raw, res_d;

  assign req_ready  = (state_q == IDLE) && !flush && !rst;
  assign resp_valid = resp_valid_q;
  assign resp_value = resp_value_q;

  always_comb begin
    signed_op = ~req_op[0];
    if (req_is_32) begin
      a_ext = signed_op ? {{32{req_a[31]}}, req_a[31:0]}
                        : {32'b0, req_a[31:0]};
      b_ext = signed_op ? {{32{req_b[31]}}, req_b[31:0]}
                        : {32'b0, req_b[31:0]};
    end else begin
      a_ext = req_a;
      b_ext = req_b;
    end
    sa     = signed_op & a_ext[63];
    sb     = signed_op & b_ext[63];
    a_mag  = sa ? -a_ext : a_ext;
    b_mag  = sb ? -b_ext : b_ext;
    b_zero = (b_ext == 64'd0);
    // a zero divisor leaves the all-ones quotient unsigned
    negq   = signed_op & (sa ^ sb) & ~b_zero;
  end

`ifdef DIV_EARLY_OUT_EN
  logic ovf;
  always_comb begin
    ovf = signed_op && (b_ext == '1) &&
          (a_ext == (req_is_32 ? 64'hFFFF_FFFF_8000_0000
                               : 64'h8000_0000_0000_0000));
  end
`endif

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      rem_d = {rem_d[63:0], quo_d[63]};
      quo_d = {quo_d[62:0], 1'b0};
      if (rem_d >= {1'b0, div_q}) begin
        rem_d    = rem_d - {1'b0, div_q};
        quo_d[0] = 1'b1;
      end
    end
  end

  always_comb begin
    q_fix   = negq_q ? -quo_q : quo_q;
    r_fix   = negr_q ? -rem_q[63:0] : rem_q[63:0];
    res_raw = is_rem_q ? r_fix : q_fix;
    res_d   = w_q ? {{32{res_raw[31]}}, res_raw[31:0]} : res_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      div_q        <= '0;
      is_rem_q     <= 1'b0;
      w_q          <= 1'b0;
      negq_q       <= 1'b0;
      negr_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_value_q <= '0;
    end else if (flush) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            is_rem_q <= req_op[1];
            w_q      <= req_is_32;
            negq_q   <= negq;
            negr_q   <= sa;
            div_q    <= b_mag;
            state_q  <= BUSY;
            rem_q    <= '0;
            quo_q    <= req_is_32 ? {a_mag[31:0], 32'b0} : a_mag;
            cnt_q    <= req_is_32 ? CNT32 : CNT64;
`ifdef DIV_EARLY_OUT_EN
            // preload final magnitudes; the fixup edge finishes the job
            if (b_zero) begin
              quo_q <= '1;
              rem_q <= {1'b0, a_mag};
              cnt_q <= '0;
            end else if (ovf) begin
              quo_q <= a_mag;
              rem_q <= '0;
              cnt_q <= '0;
            end else if (a_mag < b_mag) begin
              quo_q <= '0;
              rem_q <= {1'b0, a_mag};
              cnt_q <= '0;
            end
`endif
          end
        end
        BUSY: begin
          if (cnt_q != 7'd0) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - 7'd1;
          end else begin
            resp_value_q <= res_d;
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
